vga_timing_gen: RTL and testbench

- Parametrised raster timing generator; successor to the fixed 640x480 sync block.
- Produces horizontal/vertical sync, pixel counters, display-enable, and line/frame start strobes for any CEA/VESA-style mode.
- Porch, sync, polarity and counter width are parameters.
- Pixel-clock enable input allows running from a faster system clock without a divided clock.
- Sits between the clock source and the pixel/framebuffer fetch logic.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing types, default video modes and helpers for the VGA raster generator.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480 = '{
        h: '{active: 640, front: 16, sync: 96,  back: 48},
        v: '{active: 480, front: 10, sync: 2,   back: 33}
    };

    localparam vga_mode_t SVGA_800x600 = '{
        h: '{active: 800, front: 40, sync: 128, back: 88},
        v: '{active: 600, front: 1,  sync: 4,   back: 23}
    };

    function automatic int unsigned total(input vga_timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered sync and look-ahead active decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FRONT  = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BACK   = 48,
    parameter logic        POL    = 1'b0,
    parameter int unsigned CNT_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             active,
    output logic             wrap
);

    localparam vga_timing_t AXIS  = '{active: ACTIVE, front: FRONT, sync: SYNC, back: BACK};
    localparam int unsigned TOTAL = total(AXIS);

    if (longint'(TOTAL) > (longint'(1) << CNT_W) || SYNC == 0 || BACK == 0) begin : g_bad_timing
        $error("vga_axis_counter: TOTAL=%0d does not fit CNT_W=%0d, or SYNC/BACK is zero",
               TOTAL, CNT_W);
    end

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SY_START = CNT_W'(ACTIVE + FRONT);
    localparam logic [CNT_W-1:0] SY_END   = CNT_W'(ACTIVE + FRONT + SYNC);

    logic [CNT_W-1:0] nxt;

    // active describes the count that will be presented after this edge, so the
    // parent can register it alongside the counter with zero relative latency.
    always_comb begin
        wrap = (count == LAST);
        nxt  = count;
        if (step) begin
            nxt = wrap ? '0 : count + CNT_W'(1);
        end
        active = (nxt < ACT_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
            sync  <= ~POL;
        end else if (step) begin
            count <= nxt;
            sync  <= (nxt >= SY_START && nxt < SY_END) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel-clock enable.
// Define VGA_TIMING_PIPE_EN to delay sync/enable/strobe outputs by one enabled pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_640x480.h.active,
    parameter int unsigned H_FRONT    = VGA_640x480.h.front,
    parameter int unsigned H_SYNC     = VGA_640x480.h.sync,
    parameter int unsigned H_BACK     = VGA_640x480.h.back,
    parameter int unsigned V_ACTIVE   = VGA_640x480.v.active,
    parameter int unsigned V_FRONT    = VGA_640x480.v.front,
    parameter int unsigned V_SYNC     = VGA_640x480.v.sync,
    parameter int unsigned V_BACK     = VGA_640x480.v.back,
    parameter logic        H_SYNC_POL = 1'b0,
    parameter logic        V_SYNC_POL = 1'b0,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             PixelClock,
    input  logic             Reset_n,
    input  logic             PixelEnable,
    output logic             HorizontalSync,
    output logic             VerticalSync,
    output logic [CNT_W-1:0] HorizontalCounter,
    output logic [CNT_W-1:0] VerticalCounter,
    output logic             DisplayEnable,
    output logic             LineStart,
    output logic             FrameStart
);

    logic h_sync, h_active, h_wrap;
    logic v_sync, v_active, v_wrap;
    logic v_step;
    logic de_q, ls_q, fs_q;

    assign v_step = h_wrap & PixelEnable;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .POL    (H_SYNC_POL),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk    (PixelClock),
        .rst_n  (Reset_n),
        .step   (PixelEnable),
        .count  (HorizontalCounter),
        .sync   (h_sync),
        .active (h_active),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .POL    (V_SYNC_POL),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk    (PixelClock),
        .rst_n  (Reset_n),
        .step   (v_step),
        .count  (VerticalCounter),
        .sync   (v_sync),
        .active (v_active),
        .wrap   (v_wrap)
    );

    // Strobes only get registered on enabled edges, where the next H is 0 exactly when H wraps.
    always_ff @(posedge PixelClock or negedge Reset_n) begin
        if (!Reset_n) begin
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (PixelEnable) begin
            de_q <= h_active & v_active;
            ls_q <= h_wrap;
            fs_q <= h_wrap & v_wrap;
        end
    end

`ifdef VGA_TIMING_PIPE_EN
    always_ff @(posedge PixelClock or negedge Reset_n) begin
        if (!Reset_n) begin
            HorizontalSync <= ~H_SYNC_POL;
            VerticalSync   <= ~V_SYNC_POL;
            DisplayEnable  <= 1'b0;
            LineStart      <= 1'b0;
            FrameStart     <= 1'b0;
        end else if (PixelEnable) begin
            HorizontalSync <= h_sync;
            VerticalSync   <= v_sync;
            DisplayEnable  <= de_q;
            LineStart      <= ls_q;
            FrameStart     <= fs_q;
        end
    end
`else
    assign HorizontalSync = h_sync;
    assign VerticalSync   = v_sync;
    assign DisplayEnable  = de_q;
    assign LineStart      = ls_q;
    assign FrameStart     = fs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three parameter sets against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] v;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int ha, hf, hsw, hb;
        int va, vf, vsw, vb;
        bit hp, vp;
    } mode_t;

    typedef struct {
        int   p;
        int   h;
        int   v;
        logic hs, vs, de, ls, fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_hs, b_vs, b_de, b_ls, b_fs;
    logic [3:0] b_h, b_v;
    logic       c_hs, c_vs, c_de, c_ls, c_fs;
    logic [10:0] c_h, c_v;

    vga_timing_gen u_dut_a (
        .PixelClock (clk), .Reset_n (rst_n), .PixelEnable (en),
        .HorizontalSync (a_hs), .VerticalSync (a_vs),
        .HorizontalCounter (a_h), .VerticalCounter (a_v),
        .DisplayEnable (a_de), .LineStart (a_ls), .FrameStart (a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b0), .CNT_W (4)
    ) u_dut_b (
        .PixelClock (clk), .Reset_n (rst_n), .PixelEnable (en),
        .HorizontalSync (b_hs), .VerticalSync (b_vs),
        .HorizontalCounter (b_h), .VerticalCounter (b_v),
        .DisplayEnable (b_de), .LineStart (b_ls), .FrameStart (b_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE (800), .H_FRONT (40), .H_SYNC (128), .H_BACK (88),
        .V_ACTIVE (600), .V_FRONT (1), .V_SYNC (4), .V_BACK (23),
        .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b1), .CNT_W (11)
    ) u_dut_c (
        .PixelClock (clk), .Reset_n (rst_n), .PixelEnable (en),
        .HorizontalSync (c_hs), .VerticalSync (c_vs),
        .HorizontalCounter (c_h), .VerticalCounter (c_v),
        .DisplayEnable (c_de), .LineStart (c_ls), .FrameStart (c_fs)
    );

    int checks = 0;
    int failures = 0;
    int pix = -1;
    mode_t ma, mb, mc;
    vec_t vecs[11];

    // Pixel p is the p-th enabled edge since reset release; p < 0 means reset state.
    function automatic obs_t predict_raw(input mode_t m, input int p);
        obs_t e;
        int ht, vt, h, v, hss, vss;
        ht  = m.ha + m.hf + m.hsw + m.hb;
        vt  = m.va + m.vf + m.vsw + m.vb;
        hss = m.ha + m.hf;
        vss = m.va + m.vf;
        if (p < 0) begin
            h = ht - 1;
            v = vt - 1;
            e.hs = ~m.hp;
            e.vs = ~m.vp;
            e.de = 1'b0;
            e.ls = 1'b0;
            e.fs = 1'b0;
        end else begin
            h = p % ht;
            v = (p / ht) % vt;
            e.hs = (h >= hss && h < hss + m.hsw) ? m.hp : ~m.hp;
            e.vs = (v >= vss && v < vss + m.vsw) ? m.vp : ~m.vp;
            e.de = (h < m.ha && v < m.va);
            e.ls = (h == 0);
            e.fs = (h == 0 && v == 0);
        end
        e.h = 32'(h);
        e.v = 32'(v);
        return e;
    endfunction

    function automatic obs_t predict(input mode_t m, input int p);
        obs_t e;
        e = predict_raw(m, p);
`ifdef VGA_TIMING_PIPE_EN
        begin
            obs_t d;
            d = predict_raw(m, (p < 0) ? p : p - 1);
            e.hs = d.hs;
            e.vs = d.vs;
            e.de = d.de;
            e.ls = d.ls;
            e.fs = d.fs;
        end
`endif
        return e;
    endfunction

    task automatic compare(input string nm, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s pix=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b required h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                     nm, pix, a.h, a.v, a.hs, a.vs, a.de, a.ls, a.fs,
                     e.h, e.v, e.hs, e.vs, e.de, e.ls, e.fs);
        end
    endtask

    task automatic check_all();
        obs_t oa, ob, oc;
        oa = '{32'(a_h), 32'(a_v), a_hs, a_vs, a_de, a_ls, a_fs};
        ob = '{32'(b_h), 32'(b_v), b_hs, b_vs, b_de, b_ls, b_fs};
        oc = '{32'(c_h), 32'(c_v), c_hs, c_vs, c_de, c_ls, c_fs};
        compare("model_640x480", oa, predict(ma, pix));
        compare("model_small", ob, predict(mb, pix));
        compare("model_800x600", oc, predict(mc, pix));
    endtask

    task automatic cycle(input bit e);
        en = e;
        @(posedge clk);
        if (en && rst_n) pix++;
        #1;
        check_all();
    endtask

    task automatic check_vec(input vec_t t);
        bit bad;
        bad = (32'(a_h) != 32'(t.h)) || (32'(a_v) != 32'(t.v));
`ifndef VGA_TIMING_PIPE_EN
        bad = bad || (a_hs !== t.hs) || (a_vs !== t.vs) || (a_de !== t.de)
                  || (a_ls !== t.ls) || (a_fs !== t.fs);
`endif
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL table_p%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b required h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                     t.p, a_h, a_v, a_hs, a_vs, a_de, a_ls, a_fs,
                     t.h, t.v, t.hs, t.vs, t.de, t.ls, t.fs);
        end
    endtask

    initial begin
        ma = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        mb = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b0};
        mc = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};

        //           p     h    v    hs    vs    de    ls    fs
        vecs[0]  = '{-1,   799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{0,    0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{639,  639, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{640,  640, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{655,  655, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{656,  656, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{751,  751, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{752,  752, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{799,  799, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{800,  0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1600, 0,   2,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            while (pix < vecs[i].p) cycle(1'b1);
            check_vec(vecs[i]);
        end

        for (int i = 0; i < 6000; i++) begin
            cycle($urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 400; i++) begin
            cycle(i[0] == 1'b0);
        end

        // Asynchronous mid-frame reset, checked before any further clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        pix = -1;
        check_all();
        cycle(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
